// File: rtl/dcache_sram_nway.sv
`default_nettype none
// ============================================================================
// dcache_sram_nway : N-way set-associative line store with age-based LRU,
//                    victim reporting and a dirty-line flush sequencer.
// Rev 1.0
// ============================================================================
module dcache_sram_nway #(
   parameter int IDX_W  = 4,
   parameter int NWAYS  = 2,
   parameter int TAG_W  = 23,
   parameter int LINE_W = 256
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              enable_i,
   input  logic              write_i,
   input  logic [IDX_W-1:0]  addr_i,
   input  logic [TAG_W-1:0]  tag_i,
   input  logic [LINE_W-1:0] data_i,
   input  logic              dirty_i,
   output logic              hit_o,
   output logic [LINE_W-1:0] data_o,
   output logic [TAG_W-1:0]  tag_o,
   output logic              victim_valid_o,
   output logic              victim_dirty_o,
   input  logic              flush_i,
   output logic              busy_o,
   output logic              flush_done_o,
   output logic              wb_valid_o,
   input  logic              wb_ready_i,
   output logic [IDX_W-1:0]  wb_idx_o,
   output logic [TAG_W-1:0]  wb_tag_o,
   output logic [LINE_W-1:0] wb_data_o
);

   localparam int c_SETS  = 2**IDX_W;
   localparam int c_AGE_W = $clog2(NWAYS);
   localparam int c_PTR_W = IDX_W + c_AGE_W;
   localparam logic [c_AGE_W-1:0] c_AGE_MAX  = c_AGE_W'(NWAYS-1);
   localparam logic [c_PTR_W-1:0] c_PTR_LAST = '1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_WB   = 2'd2,
      S_DONE = 2'd3
   } state_t;

   logic [TAG_W-1:0]   tag_q   [c_SETS][NWAYS];
   logic [LINE_W-1:0]  data_q  [c_SETS][NWAYS];
   logic [NWAYS-1:0]   valid_q [c_SETS];
   logic [NWAYS-1:0]   dirty_q [c_SETS];
   logic [c_AGE_W-1:0] age_q   [c_SETS][NWAYS];

   state_t             state_q;
   logic               busy_q;
   logic               done_q;
   logic               wb_valid_q;
   logic [c_PTR_W-1:0] ptr_q;

   logic               w_acc;
   logic               w_hit;
   logic               w_vic_found;
   logic               w_update;
   logic               w_step;
   logic [c_AGE_W-1:0] w_hit_way;
   logic [c_AGE_W-1:0] w_vic_way;
   logic [c_AGE_W-1:0] w_sel_way;
   logic [IDX_W-1:0]   w_scan_set;
   logic [c_AGE_W-1:0] w_scan_way;

   assign w_scan_set = ptr_q[c_PTR_W-1:c_AGE_W];
   assign w_scan_way = ptr_q[c_AGE_W-1:0];

   // Victim: first invalid way, otherwise the oldest (age == NWAYS-1)
   always_comb begin
      w_acc       = enable_i & ~busy_q;
      w_hit       = 1'b0;
      w_hit_way   = '0;
      w_vic_way   = '0;
      w_vic_found = 1'b0;
      for (int w = 0; w < NWAYS; w++) begin
         if (valid_q[addr_i][w] && (tag_q[addr_i][w] == tag_i)) begin
            w_hit     = 1'b1;
            w_hit_way = c_AGE_W'(w);
         end
         if (!valid_q[addr_i][w] && !w_vic_found) begin
            w_vic_found = 1'b1;
            w_vic_way   = c_AGE_W'(w);
         end
      end
      if (!w_vic_found) begin
         for (int w = 0; w < NWAYS; w++) begin
            if (age_q[addr_i][w] == c_AGE_MAX) w_vic_way = c_AGE_W'(w);
         end
      end
      w_sel_way = w_hit ? w_hit_way : w_vic_way;
      w_update  = w_acc & (w_hit | write_i);
      w_step    = ((state_q == S_SCAN) &&
                   !(valid_q[w_scan_set][w_scan_way] && dirty_q[w_scan_set][w_scan_way])) ||
                  ((state_q == S_WB) && wb_ready_i);
   end

   assign hit_o          = w_acc & w_hit;
   assign data_o         = w_acc ? data_q[addr_i][w_sel_way] : '0;
   assign tag_o          = w_acc ? tag_q[addr_i][w_sel_way]  : '0;
   assign victim_valid_o = w_acc & ~w_hit & valid_q[addr_i][w_vic_way];
   assign victim_dirty_o = w_acc & ~w_hit & dirty_q[addr_i][w_vic_way];
   assign busy_o         = busy_q;
   assign flush_done_o   = done_q;
   assign wb_valid_o     = wb_valid_q;
   assign wb_idx_o       = w_scan_set;
   assign wb_tag_o       = tag_q[w_scan_set][w_scan_way];
   assign wb_data_o      = data_q[w_scan_set][w_scan_way];

   always_ff @(posedge clk_i) begin
      if (w_acc && write_i) begin
         tag_q[addr_i][w_sel_way]  <= tag_i;
         data_q[addr_i][w_sel_way] <= data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= S_IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         wb_valid_q <= 1'b0;
         ptr_q      <= '0;
         for (int s = 0; s < c_SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            for (int w = 0; w < NWAYS; w++) age_q[s][w] <= c_AGE_W'(w);
         end
      end else begin
         done_q <= 1'b0;
         if (w_update) begin
            if (write_i) begin
               valid_q[addr_i][w_sel_way] <= 1'b1;
               dirty_q[addr_i][w_sel_way] <= dirty_i;
            end
            for (int w = 0; w < NWAYS; w++) begin
               if (age_q[addr_i][w] < age_q[addr_i][w_sel_way])
                  age_q[addr_i][w] <= age_q[addr_i][w] + 1'b1;
            end
            age_q[addr_i][w_sel_way] <= '0;
         end
         case (state_q)
            S_IDLE: begin
               if (flush_i) begin
                  state_q <= S_SCAN;
                  busy_q  <= 1'b1;
                  ptr_q   <= '0;
               end
            end
            S_SCAN: begin
               if (!w_step) begin
                  state_q    <= S_WB;
                  wb_valid_q <= 1'b1;
               end else begin
                  valid_q[w_scan_set][w_scan_way] <= 1'b0;
               end
            end
            S_WB: begin
               if (wb_ready_i) begin
                  wb_valid_q                      <= 1'b0;
                  valid_q[w_scan_set][w_scan_way] <= 1'b0;
                  dirty_q[w_scan_set][w_scan_way] <= 1'b0;
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
         if (w_step) begin
            if (ptr_q == c_PTR_LAST) begin
               state_q <= S_DONE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end else begin
               state_q <= S_SCAN;
               ptr_q   <= ptr_q + 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dcache_sram_nway.sv
`default_nettype none
// ============================================================================
// tb_dcache_sram_nway : directed scoreboard bench for dcache_sram_nway (4-way, 16 sets)
// Rev 1.0
// ============================================================================
module tb_dcache_sram_nway;

   localparam int IDX_W  = 4;
   localparam int NWAYS  = 4;
   localparam int TAG_W  = 23;
   localparam int LINE_W = 256;

   logic              clk_i = 1'b0;
   logic              rst_i = 1'b0;
   logic              enable_i = 1'b0;
   logic              write_i = 1'b0;
   logic [IDX_W-1:0]  addr_i = '0;
   logic [TAG_W-1:0]  tag_i = '0;
   logic [LINE_W-1:0] data_i = '0;
   logic              dirty_i = 1'b0;
   logic              flush_i = 1'b0;
   logic              wb_ready_i = 1'b0;
   logic              hit_o, victim_valid_o, victim_dirty_o;
   logic              busy_o, flush_done_o, wb_valid_o;
   logic [LINE_W-1:0] data_o, wb_data_o;
   logic [TAG_W-1:0]  tag_o, wb_tag_o;
   logic [IDX_W-1:0]  wb_idx_o;

   dcache_sram_nway #(.IDX_W(IDX_W), .NWAYS(NWAYS), .TAG_W(TAG_W), .LINE_W(LINE_W)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .write_i(write_i),
      .addr_i(addr_i), .tag_i(tag_i), .data_i(data_i), .dirty_i(dirty_i),
      .hit_o(hit_o), .data_o(data_o), .tag_o(tag_o),
      .victim_valid_o(victim_valid_o), .victim_dirty_o(victim_dirty_o),
      .flush_i(flush_i), .busy_o(busy_o), .flush_done_o(flush_done_o),
      .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_idx_o(wb_idx_o),
      .wb_tag_o(wb_tag_o), .wb_data_o(wb_data_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int                id;
      logic              hit, vv, vd, chk;
      logic [TAG_W-1:0]  tag;
      logic [LINE_W-1:0] data;
   } lk_t;

   typedef struct {
      logic [IDX_W-1:0]  idx;
      logic [TAG_W-1:0]  tag;
      logic [LINE_W-1:0] data;
   } wb_t;

   lk_t lk_q[$];
   wb_t wb_q[$];
   lk_t me;
   int  checks   = 0;
   int  failures = 0;
   int  lk_id    = 0;

   localparam logic [LINE_W-1:0] c_AB = {32{8'hAB}};

   function automatic logic [LINE_W-1:0] line_of(input logic [TAG_W-1:0] t);
      return {8{9'h15A, t}};
   endfunction

   task automatic check(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Lookup results and write-back beats are checked against the queues
   always @(negedge clk_i) begin
      if (rst_i && enable_i) begin
         if (lk_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL lookup_unexpected: got a lookup, expected none queued");
         end else begin
            me = lk_q.pop_front();
            check($sformatf("lk%0d_hit", me.id), {255'd0, hit_o}, {255'd0, me.hit});
            check($sformatf("lk%0d_vvalid", me.id), {255'd0, victim_valid_o}, {255'd0, me.vv});
            check($sformatf("lk%0d_vdirty", me.id), {255'd0, victim_dirty_o}, {255'd0, me.vd});
            if (me.chk) begin
               check($sformatf("lk%0d_tag", me.id), LINE_W'(tag_o), LINE_W'(me.tag));
               check($sformatf("lk%0d_data", me.id), data_o, me.data);
            end
         end
      end
      if (wb_valid_o) begin
         if (wb_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL wb_unexpected: got idx %0h tag %0h, expected no write-back", wb_idx_o, wb_tag_o);
         end else begin
            check("wb_idx", LINE_W'(wb_idx_o), LINE_W'(wb_q[0].idx));
            check("wb_tag", LINE_W'(wb_tag_o), LINE_W'(wb_q[0].tag));
            check("wb_data", wb_data_o, wb_q[0].data);
            if (wb_ready_i) void'(wb_q.pop_front());
         end
      end
   end

   task automatic op(input bit wr, input logic [IDX_W-1:0] a, input logic [TAG_W-1:0] t,
                     input logic [LINE_W-1:0] d, input bit dty,
                     input bit eh, input bit ev, input bit ed, input bit ec,
                     input logic [TAG_W-1:0] et, input logic [LINE_W-1:0] edat);
      lk_t e;
      e.id = lk_id; e.hit = eh; e.vv = ev; e.vd = ed; e.chk = ec; e.tag = et; e.data = edat;
      lk_id++;
      lk_q.push_back(e);
      enable_i = 1'b1; write_i = wr; addr_i = a; tag_i = t; data_i = d; dirty_i = dty;
      @(posedge clk_i); #1;
      enable_i = 1'b0; write_i = 1'b0; dirty_i = 1'b0;
   endtask

   task automatic fill_empty(input logic [IDX_W-1:0] a, input logic [TAG_W-1:0] t, input bit dty);
      op(1'b1, a, t, line_of(t), dty, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic miss_empty(input logic [IDX_W-1:0] a, input logic [TAG_W-1:0] t);
      op(1'b0, a, t, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic push_wb(input logic [IDX_W-1:0] a, input logic [TAG_W-1:0] t);
      wb_t w;
      w.idx = a; w.tag = t; w.data = line_of(t);
      wb_q.push_back(w);
   endtask

   task automatic pulse_flush();
      flush_i = 1'b1;
      @(posedge clk_i); #1;
      flush_i = 1'b0;
   endtask

   task automatic wait_wb(input string nm);
      int n = 0;
      while (!wb_valid_o && n < 200) begin @(posedge clk_i); #1; n++; end
      check(nm, {255'd0, wb_valid_o}, {255'd0, 1'b1});
   endtask

   initial begin
      int n;
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b1;
      check("rst_busy", {255'd0, busy_o}, '0);
      check("rst_done", {255'd0, flush_done_o}, '0);
      check("rst_wbv", {255'd0, wb_valid_o}, '0);
      miss_empty(4'd3, 23'h10);

      // Set 3: four clean fills then LRU eviction of way 0
      for (int i = 0; i < 4; i++) fill_empty(4'd3, 23'(16 + i), 1'b0);
      op(1'b1, 4'd3, 23'h14, line_of(23'h14), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 23'h10, line_of(23'h10));
      op(1'b0, 4'd3, 23'h77, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 23'h11, line_of(23'h11));

      // Set 5: read refreshes way 0, dirty write-hit is evicted later
      for (int i = 0; i < 4; i++) fill_empty(4'd5, 23'(16 + i), 1'b0);
      op(1'b0, 4'd5, 23'h10, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 23'h10, line_of(23'h10));
      op(1'b1, 4'd5, 23'h14, line_of(23'h14), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 23'h11, line_of(23'h11));
      op(1'b0, 4'd5, 23'h99, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 23'h12, line_of(23'h12));
      op(1'b1, 4'd5, 23'h12, c_AB, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 23'h12, line_of(23'h12));
      op(1'b0, 4'd5, 23'h12, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 23'h12, c_AB);
      op(1'b1, 4'd5, 23'h20, line_of(23'h20), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 23'h13, line_of(23'h13));
      op(1'b1, 4'd5, 23'h21, line_of(23'h21), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 23'h10, line_of(23'h10));
      op(1'b1, 4'd5, 23'h22, line_of(23'h22), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 23'h14, line_of(23'h14));
      op(1'b1, 4'd5, 23'h23, line_of(23'h23), 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 23'h12, c_AB);

      // Flush with dirty lines at set 0 way 1 and set 15 way 3, back-pressured
      fill_empty(4'd0, 23'hA0, 1'b0);
      fill_empty(4'd0, 23'hA1, 1'b1);
      fill_empty(4'd15, 23'hF0, 1'b0);
      fill_empty(4'd15, 23'hF1, 1'b0);
      fill_empty(4'd15, 23'hF2, 1'b0);
      fill_empty(4'd15, 23'hF3, 1'b1);
      push_wb(4'd0, 23'hA1);
      push_wb(4'd15, 23'hF3);
      wb_ready_i = 1'b0;
      pulse_flush();
      check("flush1_busy", {255'd0, busy_o}, {255'd0, 1'b1});
      wait_wb("flush1_wb_seen");
      repeat (3) begin @(posedge clk_i); #1; end
      wb_ready_i = 1'b1;
      n = 0;
      while (!flush_done_o && n < 300) begin @(posedge clk_i); #1; n++; end
      check("flush1_done", {255'd0, flush_done_o}, {255'd0, 1'b1});
      check("flush1_busy_low", {255'd0, busy_o}, '0);
      check("flush1_wb_drained", LINE_W'(wb_q.size()), '0);
      wb_ready_i = 1'b0;
      @(posedge clk_i); #1;
      check("flush1_done_pulse", {255'd0, flush_done_o}, '0);
      miss_empty(4'd0, 23'hA1);
      miss_empty(4'd15, 23'hF3);
      miss_empty(4'd3, 23'h14);

      // Clean-only flush: completion cycle is fixed by the scan length
      fill_empty(4'd7, 23'h70, 1'b0);
      pulse_flush();
      n = 1;
      while (!flush_done_o && n < 200) begin @(posedge clk_i); #1; n++; end
      check("flush2_cycle", LINE_W'(n), LINE_W'(65));
      @(posedge clk_i); #1;
      miss_empty(4'd7, 23'h70);

      // Reset while a write-back is being offered
      fill_empty(4'd2, 23'h55, 1'b1);
      push_wb(4'd2, 23'h55);
      pulse_flush();
      wait_wb("flush3_wb_seen");
      rst_i = 1'b0;
      #1;
      check("rstwb_wbv", {255'd0, wb_valid_o}, '0);
      check("rstwb_busy", {255'd0, busy_o}, '0);
      wb_q.delete();
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      miss_empty(4'd2, 23'h55);
      miss_empty(4'd5, 23'h21);
      check("lookups_consumed", LINE_W'(lk_q.size()), '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected bench completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
